// File: rtl/dvs_ravens_pkg.sv
// dvs_ravens_pkg: shared arbiter types and widths for the DVS-RAVENS event interface.
package dvs_ravens_pkg;
    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;
    localparam int ARB_STAT_W = 16;
    localparam int ARB_HOLD_W = 8;
endpackage

// File: rtl/dvs_ravens_rr_pick.sv
// dvs_ravens_rr_pick: combinational picker, first eligible index from start (round-robin) or from 0 (fixed).
module dvs_ravens_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         elig,
    input  logic [$clog2(NUM_REQ)-1:0] start,
    input  logic                       rr_mode,
    output logic [$clog2(NUM_REQ)-1:0] winner,
    output logic                       found
);
    localparam int IW = $clog2(NUM_REQ);
    int j;
    // Scan from the farthest offset down so the nearest eligible index wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        j      = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = ((rr_mode ? int'(start) : 0) + k) % NUM_REQ;
            if (elig[j[IW-1:0]]) begin
                winner = j[IW-1:0];
                found  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dvs_ravens_rr_arbiter.sv
// dvs_ravens_rr_arbiter: N-requester FIFO-gated arbiter with bounded hold.
// Optional per-requester grant counters with DVS_RAVENS_ARB_STATS_EN.
module dvs_ravens_rr_arbiter
    import dvs_ravens_pkg::*;
#(
    parameter int                   NUM_REQ       = 4,
    parameter logic [NUM_REQ-1:0]   PRODUCER_MASK = NUM_REQ'(4'b0011),
    parameter bit                   RR_MODE       = 1'b1,
    parameter int                   MAX_HOLD      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         done,
    input  logic                       fifo_empty,
    input  logic                       fifo_full,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       hold_timeout
`ifdef DVS_RAVENS_ARB_STATS_EN
    ,
    output logic [NUM_REQ*ARB_STAT_W-1:0] grant_count
`endif
);
    localparam int IW = $clog2(NUM_REQ);
    arb_state_t state, state_n;
    logic [NUM_REQ-1:0]    elig;
    logic [IW-1:0]         last_winner, start, winner;
    logic                  found, rel, timeout, at_max;
    logic [ARB_HOLD_W-1:0] hold_cnt;

    assign elig = req & ~(PRODUCER_MASK & {NUM_REQ{fifo_full}}) & ~(~PRODUCER_MASK & {NUM_REQ{fifo_empty}});
    assign start = (last_winner == IW'(NUM_REQ - 1)) ? '0 : last_winner + 1'b1;
    assign at_max = hold_cnt == ARB_HOLD_W'(MAX_HOLD - 1);
    assign grant_valid = |grant;

    dvs_ravens_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .elig    (elig),
        .start   (start),
        .rr_mode (RR_MODE),
        .winner  (winner),
        .found   (found)
    );

    // A dropped request also clears elig, so elig covers both revocation causes.
    always_comb begin
        rel     = (state == ARB_GRANT) && (done[grant_id] || !elig[grant_id] || at_max);
        timeout = (state == ARB_GRANT) && at_max && !done[grant_id] && elig[grant_id];
        state_n = (state == ARB_IDLE) ? (found ? ARB_GRANT : ARB_IDLE) : (rel ? ARB_IDLE : ARB_GRANT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ARB_IDLE;
            grant        <= '0;
            grant_id     <= '0;
            hold_cnt     <= '0;
            hold_timeout <= 1'b0;
            last_winner  <= IW'(NUM_REQ - 1);
        end else begin
            state        <= state_n;
            hold_timeout <= timeout;
            if (state == ARB_IDLE && found) begin
                grant       <= NUM_REQ'(1) << winner;
                grant_id    <= winner;
                hold_cnt    <= '0;
                last_winner <= winner;
            end else if (rel) begin
                grant    <= '0;
                grant_id <= '0;
                hold_cnt <= '0;
            end else if (state == ARB_GRANT) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

`ifdef DVS_RAVENS_ARB_STATS_EN
    logic [ARB_STAT_W-1:0] stat [NUM_REQ];
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        always_ff @(posedge clk) begin
            if (rst)
                stat[i] <= '0;
            else if (state == ARB_IDLE && found && winner == IW'(i) && stat[i] != '1)
                stat[i] <= stat[i] + 1'b1;
        end
        assign grant_count[i*ARB_STAT_W +: ARB_STAT_W] = stat[i];
    end
`endif
endmodule

// File: tb/tb_dvs_ravens_rr_arbiter.sv
// tb_dvs_ravens_rr_arbiter: directed table plus randomized run against a reference model,
// one round-robin instance (MAX_HOLD=8) and one fixed-priority instance (MAX_HOLD=1).
module tb_dvs_ravens_rr_arbiter;
    localparam logic [3:0] PM = 4'b0011;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] req, done;
    logic fe, ff;
    logic [3:0] g_rr, g_fp;
    logic v_rr, v_fp, to_rr, to_fp;
    logic [1:0] id_rr, id_fp;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dvs_ravens_rr_arbiter #(.NUM_REQ(4), .PRODUCER_MASK(PM), .RR_MODE(1'b1), .MAX_HOLD(8)) dut_rr (
        .clk(clk), .rst(rst), .req(req), .done(done), .fifo_empty(fe), .fifo_full(ff),
        .grant(g_rr), .grant_valid(v_rr), .grant_id(id_rr), .hold_timeout(to_rr)
    );

    dvs_ravens_rr_arbiter #(.NUM_REQ(4), .PRODUCER_MASK(PM), .RR_MODE(1'b0), .MAX_HOLD(1)) dut_fp (
        .clk(clk), .rst(rst), .req(req), .done(done), .fifo_empty(fe), .fifo_full(ff),
        .grant(g_fp), .grant_valid(v_fp), .grant_id(id_fp), .hold_timeout(to_fp)
    );

    // Reference: g = granted index or -1, held = cycles the grant has been visible.
    typedef struct {
        int g;
        int held;
        int last;
        bit to;
    } mdl_t;

    mdl_t m_rr = '{g: -1, held: 0, last: 3, to: 1'b0};
    mdl_t m_fp = '{g: -1, held: 0, last: 3, to: 1'b0};

    function automatic bit is_elig(int i, logic [3:0] rq, bit e, bit f);
        return rq[i] && (PM[i] ? !f : !e);
    endfunction

    function automatic mdl_t step(mdl_t m, bit rr, int mh, bit r, logic [3:0] rq, logic [3:0] dn, bit e, bit f);
        mdl_t n = m;
        n.to = 1'b0;
        if (r) begin
            n.g = -1; n.held = 0; n.last = 3;
        end else if (m.g < 0) begin
            for (int k = 1; k <= 4; k++) begin
                int j = rr ? (m.last + k) % 4 : k - 1;
                if (n.g < 0 && is_elig(j, rq, e, f)) begin
                    n.g = j; n.held = 1; n.last = j;
                end
            end
        end else begin
            bit el = is_elig(m.g, rq, e, f);
            bit cap = (m.held == mh);
            if (dn[m.g] || !el || cap) begin
                n.to = cap && !dn[m.g] && el;
                n.g = -1; n.held = 0;
            end else
                n.held = m.held + 1;
        end
        return n;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] oh(int g);
        return (g < 0) ? 4'b0 : 4'(1 << g);
    endfunction

    task automatic cycle(bit r, logic [3:0] rq, logic [3:0] dn, bit e, bit f);
        rst = r; req = rq; done = dn; fe = e; ff = f;
        @(posedge clk);
        m_rr = step(m_rr, 1'b1, 8, r, rq, dn, e, f);
        m_fp = step(m_fp, 1'b0, 1, r, rq, dn, e, f);
        #1;
        chk("rr_grant", 32'(g_rr), 32'(oh(m_rr.g)));
        chk("rr_valid", 32'(v_rr), 32'(m_rr.g >= 0));
        chk("rr_id", 32'(id_rr), 32'((m_rr.g < 0) ? 0 : m_rr.g));
        chk("rr_timeout", 32'(to_rr), 32'(m_rr.to));
        chk("fp_grant", 32'(g_fp), 32'(oh(m_fp.g)));
        chk("fp_valid", 32'(v_fp), 32'(m_fp.g >= 0));
        chk("fp_id", 32'(id_fp), 32'((m_fp.g < 0) ? 0 : m_fp.g));
        chk("fp_timeout", 32'(to_fp), 32'(m_fp.to));
    endtask

    typedef struct {
        bit r;
        logic [3:0] rq, dn;
        bit e, f;
        logic [3:0] eg_rr, eg_fp;
        bit et_rr;
    } vec_t;

    vec_t tbl[34];

    function automatic vec_t mk(bit r, logic [3:0] rq, logic [3:0] dn, bit e, bit f,
                                logic [3:0] eg_rr, logic [3:0] eg_fp, bit et_rr);
        vec_t v;
        v.r = r; v.rq = rq; v.dn = dn; v.e = e; v.f = f;
        v.eg_rr = eg_rr; v.eg_fp = eg_fp; v.et_rr = et_rr;
        return v;
    endfunction

    initial begin
        rst = 1'b1; req = '0; done = '0; fe = 1'b0; ff = 1'b0;
        // round-robin rotation with done pulses
        tbl[0]  = mk(1, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);
        tbl[1]  = mk(0, 4'b1111, 4'b0000, 0, 0, 4'b0001, 4'b0001, 0);
        tbl[2]  = mk(0, 4'b1111, 4'b0001, 0, 0, 4'b0000, 4'b0000, 0);
        tbl[3]  = mk(0, 4'b1111, 4'b0000, 0, 0, 4'b0010, 4'b0001, 0);
        tbl[4]  = mk(0, 4'b1111, 4'b0010, 0, 0, 4'b0000, 4'b0000, 0);
        tbl[5]  = mk(0, 4'b1111, 4'b0000, 0, 0, 4'b0100, 4'b0001, 0);
        tbl[6]  = mk(0, 4'b1111, 4'b0100, 0, 0, 4'b0000, 4'b0000, 0);
        tbl[7]  = mk(0, 4'b1111, 4'b0000, 0, 0, 4'b1000, 4'b0001, 0);
        tbl[8]  = mk(0, 4'b1111, 4'b1000, 0, 0, 4'b0000, 4'b0000, 0);
        tbl[9]  = mk(0, 4'b1111, 4'b0000, 0, 0, 4'b0001, 4'b0001, 0);
        tbl[10] = mk(0, 4'b1111, 4'b0001, 0, 0, 4'b0000, 4'b0000, 0);
        // FIFO gating
        tbl[11] = mk(0, 4'b0011, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0);
        tbl[12] = mk(0, 4'b0011, 4'b0000, 0, 1, 4'b0000, 4'b0000, 0);
        tbl[13] = mk(0, 4'b1100, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0);
        tbl[14] = mk(0, 4'b1100, 4'b0000, 0, 0, 4'b0100, 4'b0100, 0);
        // revocation of consumer 2 by fifo_empty
        tbl[15] = mk(0, 4'b1100, 4'b0000, 1, 0, 4'b0000, 4'b0000, 0);
        tbl[16] = mk(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);
        // hold timeout on requester 1: 8 granted cycles, pulse, idle, regrant
        tbl[17] = mk(0, 4'b0010, 4'b0000, 0, 0, 4'b0010, 4'b0010, 0);
        for (int i = 18; i <= 24; i++)
            tbl[i] = mk(0, 4'b0010, 4'b0000, 0, 0, 4'b0010, (i % 2) ? 4'b0010 : 4'b0000, 0);
        tbl[25] = mk(0, 4'b0010, 4'b0000, 0, 0, 4'b0000, 4'b0010, 1);
        tbl[26] = mk(0, 4'b0010, 4'b0000, 0, 0, 4'b0010, 4'b0000, 0);
        tbl[27] = mk(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);
        // fixed priority, then reset mid-grant restores last_winner
        tbl[28] = mk(0, 4'b1010, 4'b0000, 0, 0, 4'b1000, 4'b0010, 0);
        tbl[29] = mk(0, 4'b1010, 4'b1000, 0, 0, 4'b0000, 4'b0000, 0);
        tbl[30] = mk(0, 4'b1010, 4'b0000, 0, 0, 4'b0010, 4'b0010, 0);
        tbl[31] = mk(1, 4'b1010, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0);
        tbl[32] = mk(0, 4'b1011, 4'b0000, 0, 0, 4'b0001, 4'b0001, 0);
        tbl[33] = mk(0, 4'b1011, 4'b0001, 0, 0, 4'b0000, 4'b0000, 0);

        for (int i = 0; i < 34; i++) begin
            cycle(tbl[i].r, tbl[i].rq, tbl[i].dn, tbl[i].e, tbl[i].f);
            chk($sformatf("tbl%0d_rr_grant", i), 32'(g_rr), 32'(tbl[i].eg_rr));
            chk($sformatf("tbl%0d_fp_grant", i), 32'(g_fp), 32'(tbl[i].eg_fp));
            chk($sformatf("tbl%0d_rr_timeout", i), 32'(to_rr), 32'(tbl[i].et_rr));
        end

        for (int n = 0; n < 3000; n++)
            cycle($urandom_range(0, 199) == 0, 4'($urandom), 4'($urandom & $urandom & $urandom),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dvs_ravens_rr_arbiter.md
Name: dvs_ravens_rr_arbiter

Overview:
- Parametrised N-requester successor to the two-master fixed-priority event-queue arbiter in the DVS–RAVENS interface.
- Each requester is declared either a producer (writes the FIFO event queue, blocked when the FIFO is full) or a consumer (reads it, blocked when the FIFO is empty).
- Selects among eligible requesters by fixed priority or round-robin, registers a one-hot grant, and holds it until release or timeout.
- Sits between the DVS event capture/readout masters and the shared event FIFO.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- PRODUCER_MASK, 4'b0011: bit i=1 makes requester i a producer (gated by fifo_full); bit i=0 makes it a consumer (gated by fifo_empty).
- RR_MODE, 1: 0 = fixed priority (lowest index wins); 1 = round-robin.
- MAX_HOLD, 8: maximum consecutive granted cycles before forced release, 1..255.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request, level-sensitive
- done  in  NUM_REQ  per-requester release pulse
- fifo_empty  in  1  event FIFO empty
- fifo_full  in  1  event FIFO full
- grant  out  NUM_REQ  registered one-hot grant, or all zero
- grant_valid  out  1  OR of grant
- grant_id  out  $clog2(NUM_REQ)  index of granted requester; 0 when none
- hold_timeout  out  1  one-cycle pulse when a grant is released by MAX_HOLD

Behaviour:
- Reset (clk edge with rst=1), taking priority over all other activity:
  - grant=0, grant_valid=0, grant_id=0, hold_timeout=0.
  - State=IDLE, hold counter=0, last_winner=NUM_REQ-1 (so requester 0 has first round-robin priority).
  - rst asserted mid-grant drops the grant at that edge.
- Eligibility (combinational): elig[i] = req[i] & (PRODUCER_MASK[i] ? ~fifo_full : ~fifo_empty).
- State IDLE:
  - If elig≠0, pick a winner and go to GRANT. grant/grant_id become valid at the next edge, giving 1-cycle latency from req to grant.
  - RR_MODE=0: lowest-index eligible requester wins.
  - RR_MODE=1: first eligible index searching upward from last_winner+1, wrapping modulo NUM_REQ. last_winner is updated to the winner.
- State GRANT (granted index g):
  - The hold counter increments each cycle the grant is held.
  - Release at the next edge (grant→0, go to IDLE) if any of these holds:
    - done[g]=1
    - req[g]=0
    - elig[g]=0, i.e. the FIFO went full for a producer or empty for a consumer
    - hold counter = MAX_HOLD-1
  - Release caused only by the counter also pulses hold_timeout for 1 cycle, aligned with grant falling.
  - Several release causes in the same cycle produce a single release. hold_timeout fires only if done[g]=0 and req[g]=1.
- Grant spacing:
  - Every release is followed by at least one IDLE cycle with grant=0 (no back-to-back overlap). Arbitration happens in that IDLE cycle.
  - done or req on non-granted indices is ignored while in GRANT.
- Invariants:
  - grant is always one-hot or zero.
  - grant_id == index of the set bit of grant.
  - A granted requester never sees its gating FIFO flag asserted for more than the one cycle before release.
- MAX_HOLD=1: every grant lasts exactly 1 cycle. A grant still requested at that point pulses hold_timeout.

Optional Feature:
- Macro: DVS_RAVENS_ARB_STATS_EN.
- When defined:
  - Adds output grant_count (NUM_REQ×16, flattened, requester i at bits [16i+15:16i]).
  - One 16-bit saturating counter per requester increments on each new grant issued to that requester and holds at 16'hFFFF.
  - Counters clear on rst.
- When undefined: the port and counters are absent, and all other behaviour is identical.

Decomposition:
- Shared dvs_ravens_pkg gains:
  - typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t
  - localparam ARB_STAT_W=16
  - localparam ARB_HOLD_W=8
- One combinational sub-module, dvs_ravens_rr_pick:
  - Inputs: elig vector, start index, RR_MODE.
  - Outputs: winner index and found flag.
  - Reused for any future multi-master picker.

Test Plan:
- Reset and first grant, RR_MODE=1: after reset, req=4'b1111, fifo_empty=0, fifo_full=0 → grant=0001 one cycle later. With done pulsed each grant, the sequence is 0001, 0010, 0100, 1000, 0001, with one zero cycle between grants.
- FIFO gating: fifo_full=1 with req=4'b0011 → grant stays 0. Set fifo_empty=1, fifo_full=0, req=4'b1100 → grant stays 0. Clear fifo_empty → grant=0100.
- Timeout, MAX_HOLD=8: req[1] held high and done never asserted → grant[1] high for exactly 8 cycles, hold_timeout pulses once, then IDLE, then regrant if still eligible.
- Revocation: requester 2 granted, then fifo_empty rises → grant drops at the next edge, hold_timeout=0.
- Fixed priority and reset, RR_MODE=0: req=4'b1010 repeatedly → always grant=0010. Assert rst mid-grant → grant=0 at that edge, last_winner restored.
- Stats (DVS_RAVENS_ARB_STATS_EN defined): 3 grants to requester 0 → grant_count[15:0]=3. Force 70000 grants → value saturates at 16'hFFFF.
